// File: rtl/fetch_decode_buffer.sv
// IF/ID pipeline register: captures fetched words and assembles opcode+immediate pairs into one packet.
// Latency: single-word packet 1 cycle after the word; two-word packet 1 cycle after the immediate word.
// Backpressure: i_stall freezes all state and outputs; i_flush discards everything (flush beats stall).
// Optional feature macro: INT_INJECT_EN (injects INT_OPCODE at an instruction boundary on interrupt).
module fetch_decode_buffer #(
    parameter int          IMM_FLAG_BIT = 15,
    parameter logic [15:0] INT_OPCODE   = 16'hF800
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_interrupt,
    output logic [15:0] o_instr,
    output logic [15:0] o_imm,
    output logic [31:0] o_pc,
    output logic        o_two_word,
    output logic        o_valid,
    output logic        o_busy
);

    // S_FIRST expects an opcode word; S_IMM holds an opcode and expects its immediate.
    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t      state_q,      state_d;
    logic [15:0] pend_instr_q, pend_instr_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic [15:0] instr_q,      instr_d;
    logic [15:0] imm_q,        imm_d;
    logic [31:0] pc_q,         pc_d;
    logic        two_word_q,   two_word_d;
    logic        valid_q,      valid_d;
    logic        inject;

`ifdef INT_INJECT_EN
    logic        int_pend_q,   int_pend_d;

    // Injection only at an instruction boundary, never while flushing or stalled.
    assign inject = (state_q == S_FIRST) && !i_flush && !i_stall && int_pend_q;

    // Pending request survives flush and stall; only a completed injection clears it.
    always_comb begin
        int_pend_d = (int_pend_q && !inject) || i_interrupt;
    end

    // Pending-interrupt register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            int_pend_q <= 1'b0;
        end else begin
            int_pend_q <= int_pend_d;
        end
    end
`else
    // Interrupt input has no function in this build.
    logic unused_interrupt;
    assign unused_interrupt = i_interrupt;
    assign inject           = 1'b0;
`endif

    // Next-state and output-register update, priority flush > stall > inject > normal.
    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        two_word_d   = two_word_q;
        valid_d      = valid_q;

        if (i_flush) begin
            // Drop any half-assembled pair and the word presented this cycle.
            valid_d      = 1'b0;
            two_word_d   = 1'b0;
            state_d      = S_FIRST;
            pend_instr_d = 16'h0000;
            pend_pc_d    = 32'h0000_0000;
        end else if (i_stall) begin
            // Everything holds; fetch re-presents the same word later.
            state_d = state_q;
        end else if (inject) begin
            // Synthetic INT replaces this cycle's word; its PC is the return address.
            instr_d    = INT_OPCODE;
            imm_d      = 16'h0000;
            pc_d       = i_pc;
            two_word_d = 1'b0;
            valid_d    = 1'b1;
        end else if (!i_valid) begin
            // Bubble from fetch: payload registers keep their last value.
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_FIRST: begin
                    if (i_instr[IMM_FLAG_BIT]) begin
                        // Opcode needs an immediate: park it and emit a bubble.
                        pend_instr_d = i_instr;
                        pend_pc_d    = i_pc;
                        valid_d      = 1'b0;
                        state_d      = S_IMM;
                    end else begin
                        instr_d    = i_instr;
                        imm_d      = 16'h0000;
                        pc_d       = i_pc;
                        two_word_d = 1'b0;
                        valid_d    = 1'b1;
                    end
                end
                S_IMM: begin
                    // Any word here is the immediate; its flag bit is data, not control.
                    instr_d    = pend_instr_q;
                    imm_d      = i_instr;
                    pc_d       = pend_pc_q;
                    two_word_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = S_FIRST;
                end
                default: begin
                    state_d = S_FIRST;
                end
            endcase
        end
    end

    // State, pending pair and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_FIRST;
            pend_instr_q <= 16'h0000;
            pend_pc_q    <= 32'h0000_0000;
            instr_q      <= 16'h0000;
            imm_q        <= 16'h0000;
            pc_q         <= 32'h0000_0000;
            two_word_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
            instr_q      <= instr_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            two_word_q   <= two_word_d;
            valid_q      <= valid_d;
        end
    end

    assign o_instr    = instr_q;
    assign o_imm      = imm_q;
    assign o_pc       = pc_q;
    assign o_two_word = two_word_q;
    assign o_valid    = valid_q;
    assign o_busy     = (state_q == S_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: reset, pairs, stall, flush, bubbles, interrupt injection.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Expected values are hand-derived constants per step.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic        stall;
    logic        flush;
    logic        irq;
    logic [15:0] o_instr;
    logic [15:0] o_imm;
    logic [31:0] o_pc;
    logic        o_two_word;
    logic        o_valid;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    fetch_decode_buffer dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_instr     (instr),
        .i_pc        (pc),
        .i_valid     (vld),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_interrupt (irq),
        .o_instr     (o_instr),
        .o_imm       (o_imm),
        .o_pc        (o_pc),
        .o_two_word  (o_two_word),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] w, input logic [31:0] p);
        instr = w;
        pc    = p;
        vld   = 1'b1;
    endtask

    task automatic pkt(input string tag, input logic [15:0] ei, input logic [15:0] em,
                       input logic [31:0] ep, input logic etw);
        chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, ".instr"}, {16'd0, o_instr}, {16'd0, ei});
        chk({tag, ".imm"},   {16'd0, o_imm},   {16'd0, em});
        chk({tag, ".pc"},    o_pc, ep);
        chk({tag, ".two"},   {31'd0, o_two_word}, {31'd0, etw});
    endtask

    initial begin
        rst_n = 1'b0; instr = 16'h0; pc = 32'h0; vld = 1'b0;
        stall = 1'b0; flush = 1'b0; irq = 1'b0;
        step();
        chk("rst.valid", {31'd0, o_valid}, 32'd0);
        chk("rst.busy",  {31'd0, o_busy},  32'd0);
        chk("rst.instr", {16'd0, o_instr}, 32'd0);
        chk("rst.pc",    o_pc, 32'd0);

        // 1: reset asserted mid-pair clears everything immediately
        rst_n = 1'b1;
        word(16'h1111, 32'd8); step();
        pkt("t1.pre", 16'h1111, 16'h0000, 32'd8, 1'b0);
        word(16'h8A01, 32'd2); step();
        chk("t1.busy_mid", {31'd0, o_busy}, 32'd1);
        chk("t1.hold_instr", {16'd0, o_instr}, 32'h1111);
        #2 rst_n = 1'b0;
        #1;
        chk("t1.async_valid", {31'd0, o_valid}, 32'd0);
        chk("t1.async_busy",  {31'd0, o_busy},  32'd0);
        chk("t1.async_instr", {16'd0, o_instr}, 32'd0);
        chk("t1.async_pc",    o_pc, 32'd0);
        step();
        rst_n = 1'b1;
        word(16'h0123, 32'd4); step();
        pkt("t1.post", 16'h0123, 16'h0000, 32'd4, 1'b0);

        // 2: two-word assembly
        word(16'h8A01, 32'd10); step();
        chk("t2.bubble", {31'd0, o_valid}, 32'd0);
        chk("t2.busy",   {31'd0, o_busy},  32'd1);
        word(16'h00FF, 32'd11); step();
        pkt("t2.pair", 16'h8A01, 16'h00FF, 32'd10, 1'b1);
        chk("t2.idle", {31'd0, o_busy}, 32'd0);

        // 3: stall mid-pair freezes everything
        word(16'h8A01, 32'd10); step();
        chk("t3.bubble", {31'd0, o_valid}, 32'd0);
        stall = 1'b1; word(16'h00FF, 32'd11);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3.st_valid", {31'd0, o_valid}, 32'd0);
            chk("t3.st_busy",  {31'd0, o_busy},  32'd1);
            chk("t3.st_instr", {16'd0, o_instr}, 32'h8A01);
            chk("t3.st_imm",   {16'd0, o_imm},   32'h00FF);
        end
        stall = 1'b0; step();
        pkt("t3.pair", 16'h8A01, 16'h00FF, 32'd10, 1'b1);

        // 4: flush together with stall in S_IMM
        word(16'h8A01, 32'd10); step();
        chk("t4.busy", {31'd0, o_busy}, 32'd1);
        flush = 1'b1; stall = 1'b1; word(16'h00FF, 32'd11); step();
        chk("t4.fl_valid", {31'd0, o_valid},    32'd0);
        chk("t4.fl_busy",  {31'd0, o_busy},     32'd0);
        chk("t4.fl_two",   {31'd0, o_two_word}, 32'd0);
        flush = 1'b0; stall = 1'b0; word(16'h0005, 32'd20); step();
        pkt("t4.single", 16'h0005, 16'h0000, 32'd20, 1'b0);

        // flush in S_FIRST drops a valid single word
        flush = 1'b1; word(16'h0033, 32'd30); step();
        chk("t4b.drop_valid", {31'd0, o_valid}, 32'd0);
        chk("t4b.drop_instr", {16'd0, o_instr}, 32'h0005);
        flush = 1'b0;

        // 5: alternating bubbles
        for (int k = 0; k < 4; k++) begin
            word(16'h0010 + 16'(k), 32'd100 + 32'(k)); step();
            pkt("t5.on", 16'h0010 + 16'(k), 16'h0000, 32'd100 + 32'(k), 1'b0);
            vld = 1'b0; instr = 16'h7FFF; pc = 32'd999; step();
            chk("t5.off_valid", {31'd0, o_valid}, 32'd0);
            chk("t5.off_instr", {16'd0, o_instr}, {16'd0, 16'h0010 + 16'(k)});
            chk("t5.off_pc",    o_pc, 32'd100 + 32'(k));
        end

        // immediate word with its flag bit set is still data
        word(16'h8000, 32'd40); step();
        word(16'h8123, 32'd41); step();
        pkt("t5b.pair", 16'h8000, 16'h8123, 32'd40, 1'b1);
        word(16'h0042, 32'd42); step();
        pkt("t5b.next", 16'h0042, 16'h0000, 32'd42, 1'b0);

        // 6: interrupt pulse while a pair is half-assembled
        word(16'h8A01, 32'd50); irq = 1'b1; step();
        chk("t6.busy", {31'd0, o_busy}, 32'd1);
        irq = 1'b0; word(16'h00FF, 32'd51); step();
        pkt("t6.pair", 16'h8A01, 16'h00FF, 32'd50, 1'b1);
        word(16'h0077, 32'd52); step();
`ifdef INT_INJECT_EN
        pkt("t6.int", 16'hF800, 16'h0000, 32'd52, 1'b0);
`else
        pkt("t6.noint", 16'h0077, 16'h0000, 32'd52, 1'b0);
`endif
        word(16'h0088, 32'd53); step();
        pkt("t6.after", 16'h0088, 16'h0000, 32'd53, 1'b0);
        vld = 1'b0; step();
        chk("t6.idle", {31'd0, o_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
